// File: rtl/bcd_subtractor_serial.sv
// bcd_subtractor_serial
// Digit-serial multi-digit BCD subtractor computing D = A - B - Bin over NDIG
// packed BCD digits, one digit per clock, least-significant digit first.
// The result is modulo 10^NDIG; a borrow out of the top digit shows up on Bout.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts any operation, no done)
//   start  request, sampled only in IDLE or DONE
//   A, B   minuend / subtrahend, packed BCD, digit 0 = bits [3:0]
//   Bin    borrow-in applied to digit 0
//   D      difference, packed BCD (valid from done onward)
//   Bout   final borrow, 1 when A < B + Bin
//   busy   high while digits are being processed
//   done   one-cycle pulse marking D/Bout/err valid
//   err    sticky flag: some input digit of A or B exceeded 9

module bcd_subtractor_serial #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] A,
  input  logic [4*NDIG-1:0] B,
  input  logic              Bin,
  output logic [4*NDIG-1:0] D,
  output logic              Bout,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int             CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0]  LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, next_state;

  logic [4*NDIG-1:0] a_q, b_q, d_q;
  logic [CW-1:0]     cnt;
  logic              borrow;
  logic              bout_q;
  logic              err_q;

  logic [3:0] a_dig, b_dig, d_dig;
  logic [4:0] t;
  logic       borrow_next;
  logic       err_next;
  logic       last_dig;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. DONE behaves like IDLE for start so that operations
  // can be issued back to back; start during CALC is simply not looked at.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? CALC : IDLE;
      CALC:    next_state = last_dig ? DONE : CALC;
      DONE:    next_state = start ? CALC : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state, so busy and done
  // can never overlap.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // One digit step. t is a 5-bit two's complement value covering -16..15,
  // which spans every 4-bit digit pair, so bit 4 is the borrow. Adding 10 to
  // the low nibble of a negative t gives the corrected BCD digit mod 16.
  always_comb begin
    a_dig       = a_q[{cnt, 2'b00} +: 4];
    b_dig       = b_q[{cnt, 2'b00} +: 4];
    t           = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0000, borrow};
    borrow_next = t[4];
    d_dig       = t[4] ? (t[3:0] + 4'd10) : t[3:0];
    err_next    = err_q | (a_dig > 4'd9) | (b_dig > 4'd9);
    last_dig    = (cnt == LAST);
  end

  // Datapath. Operands are captured on an accepted start so later changes on
  // A/B/Bin cannot disturb the running operation. D and Bout are left alone
  // at start and hold their previous result until the new digits land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      bout_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q    <= A;
            b_q    <= B;
            borrow <= Bin;
            cnt    <= '0;
            err_q  <= 1'b0;
          end
        end
        CALC: begin
          d_q[{cnt, 2'b00} +: 4] <= d_dig;
          borrow                 <= borrow_next;
          err_q                  <= err_next;
          cnt                    <= cnt + CW'(1);
          if (last_dig) begin
            if (err_next) begin
              d_q    <= '0;
              bout_q <= 1'b0;
            end else begin
              bout_q <= borrow_next;
            end
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  assign D    = d_q;
  assign Bout = bout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// tb_bcd_subtractor_serial
// Self-checking bench for bcd_subtractor_serial with NDIG=4. A table of
// hand-computed vectors is run through the start/done handshake, followed by
// sequences for reset mid-operation, start during CALC, back-to-back
// operation with start held high, and a random sweep against a decimal model.

module tb_bcd_subtractor_serial;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bin;
  logic [15:0] D;
  logic        Bout;
  logic        busy;
  logic        done;
  logic        err;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  bcd_subtractor_serial #(.NDIG(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .D     (D),
    .Bout  (Bout),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  // 10 ns free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value against its expectation and keep the tallies.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Packed BCD to integer, used only by the random reference model.
  function automatic int bcd2int(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Runs one operation from IDLE. Inputs are scrambled right after the start
  // edge to show they were latched. Latency counts clock edges after the
  // start-sampling edge (0 means done never arrived). protocol_bad flags busy
  // low before done or busy and done together.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic bin, input bit mid_start,
                               output logic [15:0] d_out, output logic bout_out,
                               output logic err_out, output int latency,
                               output bit protocol_bad);
    latency      = 0;
    protocol_bad = 1'b0;
    d_out        = '0;
    bout_out     = 1'b0;
    err_out      = 1'b0;
    @(posedge clk); #1;
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
    Bin = ~bin;
    if (!busy || done) protocol_bad = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (busy && done) protocol_bad = 1'b1;
      if (done) begin
        latency  = n;
        d_out    = D;
        bout_out = Bout;
        err_out  = err;
        break;
      end
      if (!busy) protocol_bad = 1'b1;
      if (mid_start && n == 1) begin
        start = 1'b1;
        A = 16'h9999;
        B = 16'h0000;
      end
      if (mid_start && n == 2) start = 1'b0;
    end
  endtask

  // Main sequence.
  initial begin
    logic [15:0] d_r;
    logic        bout_r;
    logic        err_r;
    int          lat;
    bit          bad;
    int          done_cnt;
    int          done_at[4];
    logic [15:0] d_at[4];
    bit          overlap;
    int          pulses;
    logic [15:0] ra, rb;
    logic        rbin;
    int          diff;

    tests_run    = 0;
    tests_failed = 0;

    vecs[0]  = '{16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 1'b0};
    vecs[1]  = '{16'h0007, 16'h0009, 1'b0, 16'h9998, 1'b1, 1'b0};
    vecs[2]  = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[3]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{16'h5432, 16'h1234, 1'b0, 16'h4198, 1'b0, 1'b0};
    vecs[5]  = '{16'h0500, 16'h0501, 1'b1, 16'h9998, 1'b1, 1'b0};
    vecs[6]  = '{16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[8]  = '{16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[9]  = '{16'h9000, 16'h0999, 1'b0, 16'h8001, 1'b0, 1'b0};
    vecs[10] = '{16'h0003, 16'h00F0, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[11] = '{16'h0008, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    Bin   = 1'b0;

    #12;
    checkOutput("reset D", 32'(D), 32'h0);
    checkOutput("reset Bout", 32'(Bout), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    checkOutput("reset err", 32'(err), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0,
                    d_r, bout_r, err_r, lat, bad);
      checkOutput($sformatf("vec%0d D", i), 32'(d_r), 32'(vecs[i].d));
      checkOutput($sformatf("vec%0d Bout", i), 32'(bout_r), 32'(vecs[i].bout));
      checkOutput($sformatf("vec%0d err", i), 32'(err_r), 32'(vecs[i].err));
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
      checkOutput($sformatf("vec%0d handshake", i), 32'(bad), 32'd0);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold D in IDLE", 32'(D), 32'h0005);
    checkOutput("hold busy in IDLE", 32'(busy), 32'h0);
    checkOutput("hold done in IDLE", 32'(done), 32'h0);

    applyStimulus(16'h1234, 16'h0111, 1'b0, 1'b1, d_r, bout_r, err_r, lat, bad);
    checkOutput("start in CALC D", 32'(d_r), 32'h1123);
    checkOutput("start in CALC Bout", 32'(bout_r), 32'h0);
    checkOutput("start in CALC latency", 32'(lat), 32'd4);
    checkOutput("start in CALC handshake", 32'(bad), 32'd0);
    @(posedge clk); #1;
    checkOutput("start in CALC not queued", 32'(busy), 32'h0);

    @(posedge clk); #1;
    A = 16'h2000; B = 16'h0001; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    A = 16'h0050; B = 16'h0025;
    done_cnt = 0;
    overlap  = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      if (busy && done) overlap = 1'b1;
      if (done && done_cnt < 4) begin
        done_at[done_cnt] = n;
        d_at[done_cnt]    = D;
        done_cnt++;
      end
      if (n == 14) start = 1'b0;
    end
    checkOutput("b2b done count", 32'(done_cnt), 32'd3);
    checkOutput("b2b overlap", 32'(overlap), 32'd0);
    if (done_cnt == 3) begin
      checkOutput("b2b done0 at", 32'(done_at[0]), 32'd4);
      checkOutput("b2b done1 at", 32'(done_at[1]), 32'd9);
      checkOutput("b2b done2 at", 32'(done_at[2]), 32'd14);
      checkOutput("b2b D0", 32'(d_at[0]), 32'h1999);
      checkOutput("b2b D1", 32'(d_at[1]), 32'h0025);
      checkOutput("b2b D2", 32'(d_at[2]), 32'h0025);
    end

    @(posedge clk); #1;
    A = 16'h5555; B = 16'h1111; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset D", 32'(D), 32'h0);
    checkOutput("midreset Bout", 32'(Bout), 32'h0);
    checkOutput("midreset busy", 32'(busy), 32'h0);
    checkOutput("midreset done", 32'(done), 32'h0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    checkOutput("midreset no done", 32'(pulses), 32'd0);
    applyStimulus(16'h0008, 16'h0003, 1'b0, 1'b0, d_r, bout_r, err_r, lat, bad);
    checkOutput("after reset D", 32'(d_r), 32'h0005);
    checkOutput("after reset Bout", 32'(bout_r), 32'h0);
    checkOutput("after reset latency", 32'(lat), 32'd4);

    for (int k = 0; k < 1000; k++) begin
      for (int i = 0; i < 4; i++) begin
        ra[i*4 +: 4] = 4'($urandom_range(0, 9));
        rb[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      rbin = 1'($urandom_range(0, 1));
      diff = bcd2int(ra) - bcd2int(rb) - int'(rbin);
      applyStimulus(ra, rb, rbin, 1'b0, d_r, bout_r, err_r, lat, bad);
      checkOutput($sformatf("rand%0d D", k), 32'(d_r),
                  32'(int2bcd(diff < 0 ? diff + 10000 : diff)));
      checkOutput($sformatf("rand%0d Bout", k), 32'(bout_r), 32'(diff < 0));
      checkOutput($sformatf("rand%0d err", k), 32'(err_r), 32'h0);
      checkOutput($sformatf("rand%0d latency", k), 32'(lat), 32'd4);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
